// File: rtl/calc1_req_driver_if.sv
// Host, calc1 request/response and result signals of one calc1_req_driver.
// The master side feeds transactions and plays calc1; the slave side is the driver.
interface calc1_req_driver_if;
    logic        host_valid;
    logic        host_ready;
    logic [0:3]  host_cmd;
    logic [0:31] host_op1;
    logic [0:31] host_op2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  out_resp_in;
    logic [0:31] out_data_in;
    logic        res_valid;
    logic        res_ready;
    logic [0:1]  res_resp;
    logic [0:31] res_data;
    logic        res_timeout;
    logic [0:7]  stray_cnt;

    modport master (
        output host_valid, host_cmd, host_op1, host_op2,
        output out_resp_in, out_data_in, res_ready,
        input  host_ready, req_cmd_out, req_data_out,
        input  res_valid, res_resp, res_data, res_timeout, stray_cnt
    );

    modport slave (
        input  host_valid, host_cmd, host_op1, host_op2,
        input  out_resp_in, out_data_in, res_ready,
        output host_ready, req_cmd_out, req_data_out,
        output res_valid, res_resp, res_data, res_timeout, stray_cnt
    );
endinterface

// File: rtl/calc1_req_driver.sv
// Serializes one host transaction onto a calc1 request port, waits for the
// matching response with a timeout and presents the result to the host.
module calc1_req_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 20
) (
    input  logic               c_clk,
    input  logic               reset,
    calc1_req_driver_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEND1 = 3'd1;
    localparam logic [2:0] SEND2 = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q,       state_d;
    logic        host_ready_q,  host_ready_d;
    logic [0:3]  req_cmd_q,     req_cmd_d;
    logic [0:31] req_data_q,    req_data_d;
    logic [0:31] op2_q,         op2_d;
    logic [7:0]  wait_q,        wait_d;
    logic        res_valid_q,   res_valid_d;
    logic [0:1]  res_resp_q,    res_resp_d;
    logic [0:31] res_data_q,    res_data_d;
    logic        res_timeout_q, res_timeout_d;
    logic [7:0]  stray_q,       stray_d;
    logic        resp_seen;
    logic        stray_hit;

    assign resp_seen = (bus.out_resp_in != 2'd0);
    // Responses are only expected in SEND2/WAIT; anywhere else they are strays.
    assign stray_hit = resp_seen &&
                       ((state_q == IDLE) || (state_q == SEND1) || (state_q == DONE));

    always_comb begin
        state_d       = state_q;
        host_ready_d  = host_ready_q;
        req_cmd_d     = req_cmd_q;
        req_data_d    = req_data_q;
        op2_d         = op2_q;
        wait_d        = wait_q;
        res_valid_d   = res_valid_q;
        res_resp_d    = res_resp_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        stray_d       = stray_q;

        if (stray_hit && (stray_q != 8'hFF)) begin
            stray_d = stray_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.host_valid && host_ready_q) begin
                    host_ready_d = 1'b0;
                    op2_d        = bus.host_op2;
                    if (bus.host_cmd != 4'd0) begin
                        req_cmd_d  = bus.host_cmd;
                        req_data_d = bus.host_op1;
                        state_d    = SEND1;
                    end else begin
                        res_valid_d   = 1'b1;
                        res_resp_d    = 2'd0;
                        res_data_d    = 32'd0;
                        res_timeout_d = 1'b0;
                        state_d       = DONE;
                    end
                end
            end
            SEND1: begin
                req_cmd_d  = 4'd0;
                req_data_d = op2_q;
                state_d    = SEND2;
            end
            SEND2, WAIT: begin
                req_data_d = 32'd0;
                if (resp_seen) begin
                    res_valid_d   = 1'b1;
                    res_resp_d    = bus.out_resp_in;
                    res_data_d    = bus.out_data_in;
                    res_timeout_d = 1'b0;
                    state_d       = DONE;
                end else if (state_q == SEND2) begin
                    wait_d  = 8'd0;
                    state_d = WAIT;
                end else if (wait_q == WAIT_LAST) begin
                    res_valid_d   = 1'b1;
                    res_resp_d    = 2'd0;
                    res_data_d    = 32'd0;
                    res_timeout_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d   = 1'b0;
                    res_resp_d    = 2'd0;
                    res_data_d    = 32'd0;
                    res_timeout_d = 1'b0;
                    host_ready_d  = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                host_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            host_ready_q  <= 1'b1;
            req_cmd_q     <= 4'd0;
            req_data_q    <= 32'd0;
            op2_q         <= 32'd0;
            wait_q        <= 8'd0;
            res_valid_q   <= 1'b0;
            res_resp_q    <= 2'd0;
            res_data_q    <= 32'd0;
            res_timeout_q <= 1'b0;
            stray_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            host_ready_q  <= host_ready_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            op2_q         <= op2_d;
            wait_q        <= wait_d;
            res_valid_q   <= res_valid_d;
            res_resp_q    <= res_resp_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            stray_q       <= stray_d;
        end
    end

    assign bus.host_ready   = host_ready_q;
    assign bus.req_cmd_out  = req_cmd_q;
    assign bus.req_data_out = req_data_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_resp     = res_resp_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_timeout  = res_timeout_q;
    assign bus.stray_cnt    = stray_q;

endmodule
